// File: rtl/csr_req_bridge.sv
// Request/response front-end for the CSR register file: turns one valid/ready request
// into a single select/write beat, waits out the read latency and returns the response.
module csr_req_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NUM_CSR = 32,
    parameter int NUM_RW  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_sel,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic [7:0]        err_count
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              sample;
    logic              req_err;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Full-width compares so high address bits can never alias into the decoded range.
    assign req_err = (req_addr >= ADDR_W'(NUM_CSR)) |
                     (req_write & (req_addr >= ADDR_W'(NUM_RW)));

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        csr_we    = 1'b0;
        csr_sel   = '0;
        csr_wdata = '0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                csr_sel   = addr_q;
                csr_wdata = wdata_q;
                csr_we    = write_q & ~err_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                csr_sel = addr_q;
                if (cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                csr_sel   = addr_q;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture: data only, qualified by the handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ISSUE) begin
            cnt <= CNT_W'(RD_LAT - 1);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response capture and error accounting.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (sample) begin
                rsp_rdata <= (!write_q && !err_q) ? csr_rdata : '0;
                rsp_err   <= err_q;
            end
            if (accept && req_err) begin
                err_count <= sat_inc8(err_count);
            end
        end
    end

endmodule

// File: tb/tb_csr_req_bridge.sv
// Directed bench for csr_req_bridge with a 32-entry CSR file model attached
// (0x00-0x0F writable, 0x10 constant, 0x11-0x1F read as zero).
module tb_csr_req_bridge;

    logic        clk;
    logic        reset_l;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        csr_we;
    logic [15:0] csr_sel;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    csr_req_bridge dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .csr_we    (csr_we),
        .csr_sel   (csr_sel),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model, one cycle read latency.
    logic [31:0] mem [0:15];
    logic        model_clr;

    function automatic logic [31:0] csr_lookup(input logic [15:0] sel);
        if (sel < 16'd16) return mem[sel[3:0]];
        if (sel == 16'h0010) return 32'h33675230;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'he172d365;
        end else if (csr_we && csr_sel < 16'd16) begin
            mem[csr_sel[3:0]] <= csr_wdata;
        end
        csr_rdata <= csr_lookup(csr_sel);
    end

    int we_cnt  = 0;
    int bad_we  = 0;
    always @(negedge clk) begin
        if (csr_we) we_cnt <= we_cnt + 1;
        if (csr_we && csr_sel >= 16'd16) bad_we <= bad_we + 1;
    end

    task automatic issue_req(input logic w, input logic [15:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
        issue_req(w, a, d);
        wait_rsp(lat, rd, er);
        ack_rsp();
    endtask

    task automatic test_reset();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        reset_l   = 1'b0;
        model_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        if (csr_we !== 1'b0) begin errors++; $display("FAIL reset_csr_we: got %b want 0", csr_we); end
        if (csr_sel !== 16'h0) begin errors++; $display("FAIL reset_csr_sel: got %h want 0", csr_sel); end
        if (csr_wdata !== 32'h0) begin errors++; $display("FAIL reset_csr_wdata: got %h want 0", csr_wdata); end
        if (err_count !== 8'h0) begin errors++; $display("FAIL reset_err_count: got %h want 0", err_count); end
        reset_l   = 1'b1;
        model_clr = 1'b0;
    endtask

    task automatic test_read_basic();
        int lat; logic [31:0] rd; logic er;
        txn(1'b0, 16'h0000, 32'h0, lat, rd, er);
        checks += 3;
        if (lat != 3) begin errors++; $display("FAIL read0_latency: got %0d want 3", lat); end
        if (rd !== 32'he172d365) begin errors++; $display("FAIL read0_rdata: got %h want e172d365", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL read0_err: got %b want 0", er); end
    endtask

    task automatic test_write_read();
        int lat; int we0; logic [31:0] rd; logic er;
        we0 = we_cnt;
        txn(1'b1, 16'h0005, 32'hDEADBEEF, lat, rd, er);
        checks += 5;
        if (lat != 3) begin errors++; $display("FAIL wr5_latency: got %0d want 3", lat); end
        if (er !== 1'b0) begin errors++; $display("FAIL wr5_err: got %b want 0", er); end
        if (rd !== 32'h0) begin errors++; $display("FAIL wr5_rdata: got %h want 0", rd); end
        if (we_cnt - we0 != 1) begin errors++; $display("FAIL wr5_we_cycles: got %0d want 1", we_cnt - we0); end
        if (csr_sel !== 16'h0) begin errors++; $display("FAIL idle_csr_sel: got %h want 0", csr_sel); end
        txn(1'b0, 16'h0005, 32'h0, lat, rd, er);
        checks += 2;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd5_rdata: got %h want deadbeef", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL rd5_err: got %b want 0", er); end
    endtask

    task automatic test_ro_write();
        int lat; int we0; logic [31:0] rd; logic er;
        we0 = we_cnt;
        txn(1'b1, 16'h0010, 32'h12345678, lat, rd, er);
        checks += 4;
        if (er !== 1'b1) begin errors++; $display("FAIL ro_wr_err: got %b want 1", er); end
        if (rd !== 32'h0) begin errors++; $display("FAIL ro_wr_rdata: got %h want 0", rd); end
        if (we_cnt != we0) begin errors++; $display("FAIL ro_wr_we: got %0d pulses want 0", we_cnt - we0); end
        if (bad_we != 0) begin errors++; $display("FAIL ro_we_any: got %0d want 0", bad_we); end
        txn(1'b0, 16'h0010, 32'h0, lat, rd, er);
        checks += 3;
        if (rd !== 32'h33675230) begin errors++; $display("FAIL ro_rd_rdata: got %h want 33675230", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL ro_rd_err: got %b want 0", er); end
        if (err_count !== 8'd1) begin errors++; $display("FAIL ro_err_count: got %0d want 1", err_count); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er;
        txn(1'b0, 16'h0020, 32'h0, lat, rd, er);
        checks += 2;
        if (er !== 1'b1) begin errors++; $display("FAIL oor20_err: got %b want 1", er); end
        if (rd !== 32'h0) begin errors++; $display("FAIL oor20_rdata: got %h want 0", rd); end
        txn(1'b0, 16'h0100, 32'h0, lat, rd, er);
        checks += 3;
        if (er !== 1'b1) begin errors++; $display("FAIL oor100_err: got %b want 1", er); end
        if (rd !== 32'h0) begin errors++; $display("FAIL oor100_rdata: got %h want 0", rd); end
        if (err_count !== 8'd3) begin errors++; $display("FAIL oor_err_count: got %0d want 3", err_count); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er;
        issue_req(1'b0, 16'h0005, 32'h0);
        wait_rsp(lat, rd, er);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 3;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
            if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want deadbeef", i, rsp_rdata); end
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_on_ack: got %b want 0", req_ready); end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", rsp_valid); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat, rd, er);
        ack_rsp();
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL bp_next_latency: got %0d want 3", lat); end
        if (rd !== 32'he172d365) begin errors++; $display("FAIL bp_next_rdata: got %h want e172d365", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat; int we0; logic [31:0] rd; logic er;
        we0 = we_cnt;
        issue_req(1'b1, 16'h0003, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b0;
        @(negedge clk);
        checks += 5;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready: got %b want 1", req_ready); end
        if (csr_we !== 1'b0) begin errors++; $display("FAIL rst_mid_csr_we: got %b want 0", csr_we); end
        if (err_count !== 8'h0) begin errors++; $display("FAIL rst_mid_err_count: got %h want 0", err_count); end
        if (we_cnt - we0 != 1) begin errors++; $display("FAIL rst_mid_we_pulses: got %0d want 1", we_cnt - we0); end
        reset_l = 1'b1;
        txn(1'b0, 16'h0003, 32'h0, lat, rd, er);
        checks += 2;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_mid_readback: got %h want cafef00d", rd); end
        if (we_cnt - we0 != 1) begin errors++; $display("FAIL rst_mid_no_late_we: got %0d want 1", we_cnt - we0); end
    endtask

    task automatic test_err_saturation();
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 300; i++) begin
            txn(1'b0, 16'h0020, 32'h0, lat, rd, er);
            if (i == 254) begin
                checks++;
                if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_at_255: got %h want ff", err_count); end
            end
        end
        checks += 2;
        if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_final: got %h want ff", err_count); end
        if (er !== 1'b1) begin errors++; $display("FAIL sat_last_err: got %b want 1", er); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_read();
        test_ro_write();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_write();
        test_err_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
